frame_buffer_manager: RTL

Double-buffer (ping-pong) manager between the SPI-fed device controller (writer) and the LED matrix controller (reader). Tracks which half of the shared frame memory is displayed and which is writable, and commits buffer swaps only at reader frame boundaries so no frame is ever displayed torn. It drives `frame_buffer_select` and the base addresses that both memory-arbiter clients add to their pixel offsets. It also flags writer overruns and counts displayed and repeated frames.

---
 rtl/led_pkg.sv | 14 +
 rtl/sat_counter.sv | 23 ++
 rtl/frame_buffer_manager.sv | 101 ++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED matrix datapath: frame memory geometry and
// the ping-pong buffer manager state encoding.
package led_pkg;

    localparam int ADDRESS_WIDTH = 14;
    localparam int FRAME_WORDS   = 8192;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SWAP
    } fbm_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Registered output, one cycle latency, no backpressure.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/frame_buffer_manager.sv
// Ping-pong frame buffer manager: swaps front/back only at reader frame boundaries.
// All outputs registered; a swap lands one cycle after its trigger; writer is held off while a swap is outstanding.
module frame_buffer_manager #(
    parameter int ADDRESS_WIDTH = led_pkg::ADDRESS_WIDTH,
    parameter int FRAME_WORDS   = led_pkg::FRAME_WORDS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     wr_frame_done,
    input  logic                     rd_frame_start,
    input  logic                     rd_frame_end,
    output logic                     frame_buffer_select,
    output logic [ADDRESS_WIDTH-1:0] front_base,
    output logic [ADDRESS_WIDTH-1:0] back_base,
    output logic                     wr_allow,
    output logic                     swap_pending,
    output logic                     swap_ack,
    output logic                     overrun,
    output logic [15:0]              frame_count,
    output logic [7:0]               repeat_count
);

    import led_pkg::*;

    localparam logic [ADDRESS_WIDTH-1:0] BUF1_BASE = ADDRESS_WIDTH'(FRAME_WORDS);

    fbm_state_t state;
    fbm_state_t state_next;
    logic       scanning;
    logic       enter_swap;
    logic       select_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (wr_frame_done) begin
                    state_next = (enable && (!scanning || rd_frame_end)) ? SWAP : PENDING;
                end
            end
            PENDING: begin
                // A frame end, or an idle reader, is a safe boundary to flip on.
                if (enable && (rd_frame_end || !scanning)) begin
                    state_next = SWAP;
                end
            end
            SWAP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_swap  = (state_next == SWAP);
    assign select_next = frame_buffer_select ^ enter_swap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            scanning            <= 1'b0;
            frame_buffer_select <= 1'b0;
            front_base          <= '0;
            back_base           <= BUF1_BASE;
            wr_allow            <= 1'b1;
            swap_pending        <= 1'b0;
            swap_ack            <= 1'b0;
            overrun             <= 1'b0;
            frame_count         <= '0;
        end else begin
            state               <= state_next;
            frame_buffer_select <= select_next;
            front_base          <= select_next ? BUF1_BASE : '0;
            back_base           <= select_next ? '0 : BUF1_BASE;
            wr_allow            <= (state_next == IDLE);
            swap_pending        <= (state_next == PENDING);
            swap_ack            <= enter_swap;
            // A restart keeps the reader scanning even if an end arrives alongside it.
            if (rd_frame_start) begin
                scanning <= 1'b1;
            end else if (rd_frame_end) begin
                scanning <= 1'b0;
            end
            if (wr_frame_done && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if (rd_frame_end) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    sat_counter #(
        .WIDTH (8)
    ) u_repeat_count (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (enter_swap),
        .inc     (rd_frame_end),
        .count   (repeat_count)
    );

endmodule
